// File: rtl/voice_alloc_master.sv
// voice_alloc_master: takes note-on/note-off events, picks a voice slot
// (retrigger, free slot, or round-robin steal) and writes the slot's control
// word to a voice-register block over a Wishbone classic master port.
module voice_alloc_master #(
    parameter int          NUM_VOICES = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          TMO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic                  evt_on,
    input  logic [7:0]            evt_note,
    input  logic [7:0]            evt_vel,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    input  logic                  wbm_ack_i,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic [7:0]            steal_cnt,
    output logic                  tmo_pulse
);

    localparam int TW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITE} state_t;

    state_t                state;
    logic                  ev_on;
    logic [7:0]            ev_note;
    logic [7:0]            ev_vel;
    logic [NUM_VOICES-1:0] busy;
    logic [7:0]            notes [NUM_VOICES];
    logic [TW-1:0]         steal_ptr;
    logic [TW-1:0]         tgt;
    logic [7:0]            tmo_cnt;
    logic                  bus_act;

    logic                  hit, free_found, lk_go, lk_steal;
    logic [TW-1:0]         hit_idx, free_idx, lk_tgt;
    logic [31:0]           lk_dat;

    assign evt_ready  = (state == S_IDLE);
    assign wbm_cyc_o  = bus_act;
    assign wbm_stb_o  = bus_act;
    assign wbm_we_o   = bus_act;
    assign wbm_sel_o  = 4'hF;
    assign voice_busy = busy;

    // Slot search: scan high to low so the lowest matching index wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (busy[i] && (notes[i] == ev_note)) begin
                hit     = 1'b1;
                hit_idx = TW'(i);
            end
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = TW'(i);
            end
        end
        lk_tgt   = hit ? hit_idx : (free_found ? free_idx : steal_ptr);
        lk_steal = ev_on && !hit && !free_found;
        lk_go    = ev_on || hit;
        lk_dat   = ev_on ? {14'b0, 2'b11, ev_vel, ev_note}
                         : {14'b0, 2'b00, 8'h00, ev_note};
    end

    // Control FSM, bus outputs, voice table and steal bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ev_on     <= 1'b0;
            ev_note   <= '0;
            ev_vel    <= '0;
            busy      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) notes[i] <= '0;
            steal_ptr <= '0;
            steal_cnt <= '0;
            tgt       <= '0;
            tmo_cnt   <= '0;
            tmo_pulse <= 1'b0;
            bus_act   <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            tmo_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (evt_valid) begin
                        ev_on   <= evt_on;
                        ev_note <= evt_note;
                        ev_vel  <= evt_vel;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lk_go) begin
                        tgt       <= lk_tgt;
                        bus_act   <= 1'b1;
                        wbm_adr_o <= BASE_ADDR + 32'd8 + (32'(lk_tgt) << 2);
                        wbm_dat_o <= lk_dat;
                        tmo_cnt   <= '0;
                        state     <= S_WRITE;
                        // Steal bookkeeping commits here even if the write later times out.
                        if (lk_steal) begin
                            steal_ptr <= (steal_ptr == TW'(NUM_VOICES - 1)) ? '0 : steal_ptr + TW'(1);
                            if (steal_cnt != 8'hFF) steal_cnt <= steal_cnt + 8'd1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    // An ack on the last allowed cycle still counts as success.
                    if (wbm_ack_i) begin
                        busy[tgt]  <= ev_on;
                        notes[tgt] <= ev_note;
                        bus_act    <= 1'b0;
                        wbm_adr_o  <= '0;
                        wbm_dat_o  <= '0;
                        tmo_cnt    <= '0;
                        state      <= S_IDLE;
                    end else if (tmo_cnt == 8'(TMO_CYCLES - 1)) begin
                        bus_act    <= 1'b0;
                        wbm_adr_o  <= '0;
                        wbm_dat_o  <= '0;
                        tmo_cnt    <= '0;
                        tmo_pulse  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_alloc_master.sv
// Scoreboarded bench for voice_alloc_master: directed scenarios plus random
// note traffic against a slot-table reference model.
module tb_voice_alloc_master;

    localparam int NV  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          evt_valid = 1'b0;
    logic          evt_ready;
    logic          evt_on = 1'b0;
    logic [7:0]    evt_note = '0;
    logic [7:0]    evt_vel = '0;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0]   wbm_adr_o, wbm_dat_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_ack_i = 1'b0;
    logic [NV-1:0] voice_busy;
    logic [7:0]    steal_cnt;
    logic          tmo_pulse;

    voice_alloc_master #(.NUM_VOICES(NV), .BASE_ADDR(32'h0), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on),
        .evt_note(evt_note), .evt_vel(evt_vel),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i),
        .voice_busy(voice_busy), .steal_cnt(steal_cnt), .tmo_pulse(tmo_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          tmo;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: slot table as plain arrays
    bit          m_busy[NV];
    logic [7:0]  m_note[NV];
    int          m_sp = 0;
    int          m_sc = 0;

    bit          ack_en  = 1'b1;
    bit          spur_en = 1'b0;
    int          ack_dly = 1;
    bit          in_rst  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NV; i++) begin
            m_busy[i] = 1'b0;
            m_note[i] = '0;
        end
        m_sp = 0;
        m_sc = 0;
    endtask

    // Apply one accepted event to the model and queue the expected bus write.
    task automatic model_event(input bit on, input logic [7:0] note, input logic [7:0] vel, input bit acked);
        int   t = -1;
        exp_t e;
        for (int i = 0; i < NV; i++)
            if (t < 0 && m_busy[i] && m_note[i] == note) t = i;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (t < 0 && !m_busy[i]) t = i;
            if (t < 0) begin
                t    = m_sp;
                m_sp = (m_sp + 1) % NV;
                if (m_sc < 255) m_sc++;
            end
            e.adr = 32'(8 + 4 * t);
            e.dat = 32'h0003_0000 | (32'(vel) << 8) | 32'(note);
            e.tmo = !acked;
            q.push_back(e);
            if (acked) begin
                m_busy[t] = 1'b1;
                m_note[t] = note;
            end
        end else if (t >= 0) begin
            e.adr = 32'(8 + 4 * t);
            e.dat = 32'(note);
            e.tmo = !acked;
            q.push_back(e);
            if (acked) m_busy[t] = 1'b0;
        end
    endtask

    // Present one event once the block is ready; the slave policy is set for it.
    task automatic send(input bit on, input logic [7:0] note, input logic [7:0] vel, input bit acked);
        int n = 0;
        @(negedge clk);
        while (!evt_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            checks++;
            $display("FAIL send_wait actual=not_ready expected=ready");
        end
        ack_en    = acked;
        ack_dly   = $urandom_range(0, 2);
        evt_on    = on;
        evt_note  = note;
        evt_vel   = vel;
        evt_valid = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        model_event(on, note, vel, acked);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || wbm_cyc_o || !evt_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            checks++;
            $display("FAIL drain actual=busy expected=idle");
        end
        @(negedge clk);
    endtask

    // Wishbone slave: acks after ack_dly cycles of stb, optional stray acks while idle.
    initial begin
        int wc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
                wc = 0;
            end else if (wbm_cyc_o && wbm_stb_o && ack_en) begin
                if (wc >= ack_dly) wbm_ack_i = 1'b1;
                else wc++;
            end else begin
                wc = 0;
                if (!wbm_cyc_o && spur_en && $urandom_range(0, 3) == 0) wbm_ack_i = 1'b1;
            end
        end
    end

    // Monitor: pops an expectation at every new bus cycle and checks its outcome.
    initial begin
        bit   prev_cyc = 1'b0;
        bit   prev_tmo = 1'b0;
        bit   have_cur = 1'b0;
        int   len = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                prev_cyc = 1'b0;
                prev_tmo = 1'b0;
                have_cur = 1'b0;
                len      = 0;
            end else begin
                if (tmo_pulse && prev_tmo) chk("tmo_width", 32'(tmo_pulse), 32'(0));
                if (wbm_cyc_o && !prev_cyc) begin
                    if (q.size() == 0) begin
                        chk("unexpected_cyc", 32'(wbm_adr_o), 32'hFFFF_FFFF);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        chk("wr_adr", wbm_adr_o, cur.adr);
                        chk("wr_dat", wbm_dat_o, cur.dat);
                        chk("wr_stb_we_sel", 32'({wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'h3F);
                    end
                    len = 1;
                end else if (wbm_cyc_o) begin
                    len++;
                    if (have_cur) chk("adr_stable", wbm_adr_o, cur.adr);
                end else if (prev_cyc) begin
                    if (have_cur) begin
                        if (cur.tmo) begin
                            chk("tmo_len", 32'(len), 32'(TMO));
                            chk("tmo_pulse", 32'(tmo_pulse), 32'(1));
                        end else begin
                            chk("ack_no_tmo", 32'(tmo_pulse), 32'(0));
                        end
                        chk("voice_busy", 32'(voice_busy), m_busy_vec());
                        chk("steal_cnt", 32'(steal_cnt), 32'(m_sc));
                    end
                    have_cur = 1'b0;
                end else if (tmo_pulse) begin
                    chk("tmo_spurious", 32'(tmo_pulse), 32'(0));
                end
                if (!wbm_cyc_o) chk("idle_adr_dat", wbm_adr_o | wbm_dat_o, 32'(0));
                prev_cyc = wbm_cyc_o;
                prev_tmo = tmo_pulse;
            end
        end
    end

    initial begin
        int n;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'(0));
        chk("rst_busy", 32'(voice_busy), 32'(0));
        chk("rst_steal", 32'(steal_cnt), 32'(0));
        chk("rst_tmo", 32'(tmo_pulse), 32'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(evt_ready), 32'(1));

        // Single note-on, then a hit and a miss note-off
        send(1'b1, 8'd60, 8'd100, 1'b1);
        drain();
        chk("on60_busy", 32'(voice_busy), 32'h01);
        send(1'b0, 8'd60, 8'd0, 1'b1);
        drain();
        chk("off60_busy", 32'(voice_busy), 32'h00);
        send(1'b0, 8'd61, 8'd0, 1'b1);
        @(negedge clk);
        chk("miss_lookup_ready", 32'(evt_ready), 32'(0));
        @(negedge clk);
        chk("miss_t2_ready", 32'(evt_ready), 32'(1));
        chk("miss_t2_cyc", 32'(wbm_cyc_o), 32'(0));

        // Fill all voices, then two steals (voice 0, then voice 1)
        for (int k = 1; k <= 10; k++) send(1'b1, 8'(k), 8'(k * 7), 1'b1);
        drain();
        chk("fill_busy", 32'(voice_busy), 32'hFF);
        chk("fill_steal_cnt", 32'(steal_cnt), 32'(2));

        // Unacknowledged write: steal still counted, table untouched
        send(1'b1, 8'd99, 8'd50, 1'b0);
        drain();
        chk("tmo_busy", 32'(voice_busy), 32'hFF);
        chk("tmo_steal_cnt", 32'(steal_cnt), 32'(3));

        // Random traffic with stray acks while idle
        spur_en = 1'b1;
        repeat (150) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)),
                 8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        spur_en = 1'b0;
        chk("rand_busy", 32'(voice_busy), m_busy_vec());

        // Reset in the middle of a write
        send(1'b1, 8'd77, 8'd1, 1'b0);
        n = 0;
        while (!wbm_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_write_seen", 32'(wbm_cyc_o), 32'(1));
        @(posedge clk);
        #2;
        in_rst = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("arst_cyc_stb_we", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'(0));
        chk("arst_adr_dat", wbm_adr_o | wbm_dat_o, 32'(0));
        chk("arst_busy", 32'(voice_busy), 32'(0));
        chk("arst_steal", 32'(steal_cnt), 32'(0));
        chk("arst_tmo", 32'(tmo_pulse), 32'(0));
        q.delete();
        m_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_ready", 32'(evt_ready), 32'(1));

        send(1'b1, 8'd60, 8'd100, 1'b1);
        drain();
        chk("post_rst_busy", 32'(voice_busy), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
